// File: rtl/flash_boot_pkg.sv
`default_nettype none
// ==== flash_boot_pkg : state encodings and SPI flash opcodes for the boot loader ====
// ==== rev 1.0 ====
package flash_boot_pkg;

  localparam logic [7:0] OP_RELEASE_PD = 8'hAB;
  localparam logic [7:0] OP_READ       = 8'h03;
  localparam logic [7:0] OP_DUMMY      = 8'h00;

  typedef enum logic [3:0] {
    ST_WAKE_TX   = 4'd0,
    ST_WAKE_CS   = 4'd1,
    ST_WAKE_WAIT = 4'd2,
    ST_CMD       = 4'd3,
    ST_A2        = 4'd4,
    ST_A1        = 4'd5,
    ST_A0        = 4'd6,
    ST_DATA      = 4'd7,
    ST_FINISH    = 4'd8,
    ST_ERROR     = 4'd9,
    ST_DONE      = 4'd10
  } boot_state_t;

  typedef enum logic [1:0] {
    XF_IDLE  = 2'd0,
    XF_GUARD = 2'd1,
    XF_WAIT  = 2'd2
  } xfer_phase_t;

endpackage
`default_nettype wire

// File: rtl/flash_boot_loader_xfer.sv
`default_nettype none
// ==== flash_byte_xfer : one SPI byte issue/guard/wait handshake with timeout ====
// ==== rev 1.0 ====
module flash_byte_xfer #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       input_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       spi_ready,
  input  logic [7:0] spi_do,
  output logic       spi_we,
  output logic [7:0] spi_di,
  output logic       done,
  output logic       timeout,
  output logic [7:0] rx_byte
);
  import flash_boot_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  xfer_phase_t      phase, phase_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             tmo_hit;

  // wait_cnt equals the number of cycles elapsed since the strobe cycle
  assign tmo_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign spi_di  = spi_we ? tx_byte : 8'h00;
  assign rx_byte = spi_do;

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      phase    <= XF_IDLE;
      wait_cnt <= '0;
    end else begin
      phase <= phase_next;
      if (spi_we)
        wait_cnt <= CNT_W'(1);
      else if (phase != XF_IDLE)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    phase_next = phase;
    spi_we     = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    case (phase)
      XF_IDLE: begin
        if (start && spi_ready) begin
          spi_we     = 1'b1;
          phase_next = XF_GUARD;
        end
      end
      // core may still report ready in the cycle after the strobe
      XF_GUARD: phase_next = XF_WAIT;
      XF_WAIT: begin
        if (spi_ready) begin
          done       = 1'b1;
          phase_next = XF_IDLE;
        end else if (tmo_hit) begin
          timeout    = 1'b1;
          phase_next = XF_IDLE;
        end
      end
      default: phase_next = XF_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/flash_boot_loader.sv
`default_nettype none
// ==== flash_boot_loader : wakes SPI flash, copies the boot image to block RAM, then hands SPI to the CPU ====
// ==== rev 1.0 ====
module flash_boot_loader #(
  parameter logic [23:0] FLASH_ADDR     = 24'h100000,
  parameter int          LOAD_WORDS     = 4096,
  parameter int          WAKE_CYCLES    = 48,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic        input_clk,
  input  logic        reset,
  input  logic        cpu_spi_we,
  input  logic [7:0]  cpu_spi_di,
  input  logic        cpu_spi_ss_reset,
  output logic [7:0]  cpu_spi_do,
  output logic        cpu_spi_ready,
  output logic        spi_we,
  output logic [7:0]  spi_di,
  output logic        spi_ss_reset,
  input  logic [7:0]  spi_do,
  input  logic        spi_ready,
  output logic [3:0]  mem_we,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        boot_done,
  output logic        boot_error
);
  import flash_boot_pkg::*;

  localparam int          WAKE_W    = $clog2(WAKE_CYCLES + 1);
  localparam logic [11:0] LAST_WORD = 12'(LOAD_WORDS - 1);

  boot_state_t       state, state_next;
  logic [WAKE_W-1:0] wake_cnt;
  logic [1:0]        byte_idx;
  logic [11:0]       word_idx;
  logic [23:0]       word_buf;
  logic              mem_we_r;
  logic [11:0]       mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              error_r;
  logic              pass_en;
  logic              sends_byte;
  logic              xf_start;
  logic [7:0]        xf_tx;
  logic              xf_we;
  logic [7:0]        xf_di;
  logic              xf_done;
  logic              xf_timeout;
  logic [7:0]        xf_rx;

  // keeps the strobe quiet while reset is held even though the core reports ready
  assign xf_start = sends_byte && !reset;

  flash_byte_xfer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_xfer (
    .input_clk (input_clk),
    .reset     (reset),
    .start     (xf_start),
    .tx_byte   (xf_tx),
    .spi_ready (spi_ready),
    .spi_do    (spi_do),
    .spi_we    (xf_we),
    .spi_di    (xf_di),
    .done      (xf_done),
    .timeout   (xf_timeout),
    .rx_byte   (xf_rx)
  );

  always_comb begin
    state_next = state;
    sends_byte = 1'b0;
    xf_tx      = OP_DUMMY;
    case (state)
      ST_WAKE_TX: begin
        sends_byte = 1'b1;
        xf_tx      = OP_RELEASE_PD;
        if (xf_done) state_next = ST_WAKE_CS;
      end
      ST_WAKE_CS:   state_next = ST_WAKE_WAIT;
      ST_WAKE_WAIT: if (wake_cnt == WAKE_W'(WAKE_CYCLES - 1)) state_next = ST_CMD;
      ST_CMD: begin
        sends_byte = 1'b1;
        xf_tx      = OP_READ;
        if (xf_done) state_next = ST_A2;
      end
      ST_A2: begin
        sends_byte = 1'b1;
        xf_tx      = FLASH_ADDR[23:16];
        if (xf_done) state_next = ST_A1;
      end
      ST_A1: begin
        sends_byte = 1'b1;
        xf_tx      = FLASH_ADDR[15:8];
        if (xf_done) state_next = ST_A0;
      end
      ST_A0: begin
        sends_byte = 1'b1;
        xf_tx      = FLASH_ADDR[7:0];
        if (xf_done) state_next = ST_DATA;
      end
      ST_DATA: begin
        sends_byte = 1'b1;
        xf_tx      = OP_DUMMY;
        if (xf_done && byte_idx == 2'd3 && word_idx == LAST_WORD) state_next = ST_FINISH;
      end
      ST_FINISH: state_next = ST_DONE;
      ST_ERROR:  state_next = ST_FINISH;
      ST_DONE:   state_next = ST_DONE;
      default:   state_next = ST_WAKE_TX;
    endcase
    if (sends_byte && xf_timeout) state_next = ST_ERROR;
  end

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      state       <= ST_WAKE_TX;
      wake_cnt    <= '0;
      byte_idx    <= 2'd0;
      word_idx    <= 12'd0;
      word_buf    <= 24'd0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 12'd0;
      mem_wdata_r <= 32'd0;
      error_r     <= 1'b0;
      pass_en     <= 1'b0;
    end else begin
      state    <= state_next;
      mem_we_r <= 1'b0;
      // pass-through opens one cycle after DONE entry so an in-flight CPU strobe is dropped
      pass_en  <= (state == ST_DONE);
      if (state == ST_WAKE_WAIT) wake_cnt <= wake_cnt + 1'b1;
      else                       wake_cnt <= '0;
      if (state == ST_ERROR) error_r <= 1'b1;
      if (state == ST_DATA && xf_done) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0: word_buf[7:0]   <= xf_rx;
          2'd1: word_buf[15:8]  <= xf_rx;
          2'd2: word_buf[23:16] <= xf_rx;
          default: begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= word_idx;
            mem_wdata_r <= {xf_rx, word_buf};
            if (word_idx != LAST_WORD) word_idx <= word_idx + 12'd1;
          end
        endcase
      end
    end
  end

  assign spi_we        = pass_en ? cpu_spi_we : xf_we;
  assign spi_di        = pass_en ? cpu_spi_di : xf_di;
  assign spi_ss_reset  = pass_en ? cpu_spi_ss_reset
                                 : (reset || state == ST_WAKE_CS || state == ST_FINISH);
  assign cpu_spi_do    = pass_en ? spi_do : 8'h00;
  assign cpu_spi_ready = pass_en && spi_ready;
  assign mem_we        = {4{mem_we_r}};
  assign mem_addr      = mem_addr_r;
  assign mem_wdata     = mem_wdata_r;
  assign cpu_hold      = (state != ST_DONE);
  assign boot_done     = (state == ST_DONE);
  assign boot_error    = error_r;

endmodule
`default_nettype wire

// File: tb/tb_flash_boot_loader.sv
`default_nettype none
// ==== tb_flash_boot_loader : directed bench with a behavioural SPI core + flash model ====
// ==== rev 1.0 ====
module tb_flash_boot_loader;

  localparam int LW   = 4;
  localparam int WAKE = 8;
  localparam int TMO  = 100;

  logic        input_clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_spi_we = 1'b0;
  logic [7:0]  cpu_spi_di = 8'h00;
  logic        cpu_spi_ss_reset = 1'b0;
  logic [7:0]  cpu_spi_do;
  logic        cpu_spi_ready;
  logic        spi_we;
  logic [7:0]  spi_di;
  logic        spi_ss_reset;
  logic [7:0]  spi_do = 8'h00;
  logic        spi_ready;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        boot_done;
  logic        boot_error;

  always #5 input_clk = ~input_clk;

  flash_boot_loader #(
    .FLASH_ADDR(24'h100000), .LOAD_WORDS(LW), .WAKE_CYCLES(WAKE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .input_clk(input_clk), .reset(reset),
    .cpu_spi_we(cpu_spi_we), .cpu_spi_di(cpu_spi_di), .cpu_spi_ss_reset(cpu_spi_ss_reset),
    .cpu_spi_do(cpu_spi_do), .cpu_spi_ready(cpu_spi_ready),
    .spi_we(spi_we), .spi_di(spi_di), .spi_ss_reset(spi_ss_reset),
    .spi_do(spi_do), .spi_ready(spi_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .boot_done(boot_done), .boot_error(boot_error)
  );

  // SPI core + flash: 3 busy cycles per byte; data bytes count up from 0x00 after 4 command bytes
  int         busy = 0;
  logic       stuck = 1'b0;
  int         sess = 0;
  int         nbytes = 0;
  int         stall_byte = 0;
  logic [7:0] pend = 8'h00;

  always @(posedge input_clk) begin
    if (reset) begin
      busy <= 0; stuck <= 1'b0; sess <= 0; nbytes <= 0; spi_do <= 8'h00; pend <= 8'h00;
    end else begin
      if (spi_ss_reset) sess <= 0;
      if (spi_we) begin
        busy   <= 3;
        nbytes <= nbytes + 1;
        if (nbytes + 1 == stall_byte) stuck <= 1'b1;
        pend   <= (sess >= 4) ? 8'(sess - 4) : 8'(8'hC0 + sess);
        spi_do <= 8'hEE;
        sess   <= sess + 1;
      end else if (busy == 1) begin
        busy   <= 0;
        spi_do <= pend;
      end else if (busy > 1) begin
        busy <= busy - 1;
      end
    end
  end
  assign spi_ready = (busy == 0) && !stuck;

  // bus monitor: MOSI log (256 marks a chip-select release), event cycles, RAM image
  int          cyc = 0;
  int          log_q[$];
  int          we_t[$];
  int          ss_t[$];
  int          wr_cnt = 0;
  int          bad_we = 0;
  logic [31:0] ram [4];

  always @(posedge input_clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      log_q.delete(); we_t.delete(); ss_t.delete();
      wr_cnt <= 0; bad_we <= 0;
      for (int i = 0; i < 4; i++) ram[i] <= 32'hDEADBEEF;
    end else begin
      if (spi_we) begin log_q.push_back(int'(spi_di)); we_t.push_back(cyc); end
      if (spi_ss_reset) begin log_q.push_back(256); ss_t.push_back(cyc); end
      if (mem_we != 4'h0) begin
        wr_cnt <= wr_cnt + 1;
        if (mem_we != 4'hF) bad_we <= bad_we + 1;
        if (mem_addr < 12'd4) ram[mem_addr[1:0]] <= mem_wdata;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string w);
    chk({w, "_spi_we"},        32'(spi_we),        32'h0);
    chk({w, "_spi_di"},        32'(spi_di),        32'h0);
    chk({w, "_spi_ss_reset"},  32'(spi_ss_reset),  32'h1);
    chk({w, "_mem_we"},        32'(mem_we),        32'h0);
    chk({w, "_mem_addr"},      32'(mem_addr),      32'h0);
    chk({w, "_mem_wdata"},     mem_wdata,          32'h0);
    chk({w, "_cpu_hold"},      32'(cpu_hold),      32'h1);
    chk({w, "_boot_done"},     32'(boot_done),     32'h0);
    chk({w, "_boot_error"},    32'(boot_error),    32'h0);
    chk({w, "_cpu_spi_ready"}, 32'(cpu_spi_ready), 32'h0);
    chk({w, "_cpu_spi_do"},    32'(cpu_spi_do),    32'h0);
  endtask

  task automatic wait_boot(input int budget, output int leak);
    int n;
    n    = 0;
    leak = 0;
    while (boot_done !== 1'b1 && n < budget) begin
      @(negedge input_clk);
      if (boot_done !== 1'b1 && (spi_di === 8'h5A || cpu_spi_ready !== 1'b0 || cpu_spi_do !== 8'h00))
        leak++;
      n++;
    end
  endtask

  initial begin : main
    logic [31:0] exp_words [4];
    int          exp_log[$];
    int          leak;
    int          n;

    exp_words = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    exp_log = {32'hAB, 256, 32'h03, 32'h10, 32'h00, 32'h00};
    for (int i = 0; i < 16; i++) exp_log.push_back(0);
    exp_log.push_back(256);

    // reset state
    repeat (3) @(negedge input_clk);
    chk_reset("rst");

    // normal boot while the CPU hammers its flash register
    cpu_spi_we = 1'b1; cpu_spi_di = 8'h5A; cpu_spi_ss_reset = 1'b1;
    reset = 1'b0;
    wait_boot(2000, leak);
    chk("boot_done", 32'(boot_done), 32'h1);
    chk("cpu_strobe_leak", leak, 0);
    chk("entry_we_dropped", 32'(spi_we), 32'h0);
    chk("entry_ss_dropped", 32'(spi_ss_reset), 32'h0);
    cpu_spi_we = 1'b0; cpu_spi_ss_reset = 1'b0;
    chk("cpu_hold_released", 32'(cpu_hold), 32'h0);
    chk("no_error", 32'(boot_error), 32'h0);
    chk("mosi_len", log_q.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
      chk($sformatf("mosi[%0d]", i), log_q[i], exp_log[i]);
    chk("wake_spacing", 32'((we_t[1] - ss_t[0]) >= WAKE), 32'h1);
    chk("wr_cnt", wr_cnt, LW);
    chk("we_pattern", bad_we, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("ram[%0d]", i), ram[i], exp_words[i]);

    // pass-through
    @(negedge input_clk);
    chk("pt_ready_idle", 32'(cpu_spi_ready), 32'h1);
    chk("pt_do_idle", 32'(cpu_spi_do), 32'h0F);
    cpu_spi_we = 1'b1; cpu_spi_di = 8'h9F;
    #1;
    chk("pt_we", 32'(spi_we), 32'h1);
    chk("pt_di", 32'(spi_di), 32'h9F);
    @(negedge input_clk);
    cpu_spi_we = 1'b0;
    chk("pt_ready_busy", 32'(cpu_spi_ready), 32'h0);
    n = 0;
    while (cpu_spi_ready !== 1'b1 && n < 20) begin @(negedge input_clk); n++; end
    chk("pt_ready_back", 32'(cpu_spi_ready), 32'h1);
    chk("pt_rx", 32'(cpu_spi_do), 32'hC0);
    cpu_spi_ss_reset = 1'b1;
    #1;
    chk("pt_ss", 32'(spi_ss_reset), 32'h1);
    @(negedge input_clk);
    cpu_spi_ss_reset = 1'b0;
    chk("done_no_mem_we", wr_cnt, LW);

    // reset in the middle of word 1
    reset = 1'b1;
    repeat (2) @(negedge input_clk);
    reset = 1'b0;
    n = 0;
    while (wr_cnt < 1 && n < 2000) begin @(negedge input_clk); n++; end
    chk("midload_first_word", wr_cnt, 1);
    repeat (6) @(negedge input_clk);
    #2 reset = 1'b1;
    #1;
    chk_reset("midload");
    repeat (2) @(negedge input_clk);
    reset = 1'b0;
    wait_boot(2000, leak);
    chk("restart_done", 32'(boot_done), 32'h1);
    chk("restart_first_byte", log_q[0], 32'hAB);
    chk("restart_wr_cnt", wr_cnt, LW);
    for (int i = 0; i < 4; i++) chk($sformatf("restart_ram[%0d]", i), ram[i], exp_words[i]);

    // flash stalls on the third byte (A2)
    reset = 1'b1;
    stall_byte = 3;
    repeat (2) @(negedge input_clk);
    reset = 1'b0;
    wait_boot(2000, leak);
    chk("tmo_done", 32'(boot_done), 32'h1);
    chk("tmo_error", 32'(boot_error), 32'h1);
    chk("tmo_cpu_hold", 32'(cpu_hold), 32'h0);
    chk("tmo_no_mem_we", wr_cnt, 0);
    chk("tmo_ss_pulses", ss_t.size(), 2);
    chk("tmo_mosi_len", log_q.size(), 5);
    // strobe T, counter hits 100 at T+100, ERROR T+101, FINISH pulse T+102
    chk("tmo_latency", ss_t[1] - we_t[2], 102);

    // boot_error clears only on reset
    repeat (3) @(negedge input_clk);
    chk("tmo_error_sticky", 32'(boot_error), 32'h1);
    reset = 1'b1;
    stall_byte = 0;
    @(negedge input_clk);
    chk("error_cleared", 32'(boot_error), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flash_boot_loader.md
# flash_boot_loader

Boot sequencer for the SPI flash byte engine. Out of reset it holds the CPU and drives the SPI core itself: wake the flash, issue a READ command, and copy LOAD_WORDS 32-bit words into block RAM. After the copy it releases the CPU and passes the SPI core through to the CPU's memory-mapped flash register. It sits between the CPU flash register decode, the SPI core and the block RAM write port.

## Interface
- FLASH_ADDR, 24'h100000, flash byte address of the image.
- LOAD_WORDS, 4096, words to copy (1..4096).
- WAKE_CYCLES, 48, idle cycles after release-power-down (≥3 µs at 12 MHz).
- TIMEOUT_CYCLES, 65535, max cycles waiting for spi_ready per byte.
- input_clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cpu_spi_we  in  1  CPU byte write strobe to flash register
- cpu_spi_di  in  8  CPU transmit byte
- cpu_spi_ss_reset  in  1  CPU chip-select release request
- cpu_spi_do  out  8  received byte to CPU
- cpu_spi_ready  out  1  SPI idle, seen by CPU
- spi_we  out  1  byte start strobe to SPI core
- spi_di  out  8  transmit byte to SPI core
- spi_ss_reset  out  1  chip-select release to SPI core
- spi_do  in  8  received byte from SPI core
- spi_ready  in  1  SPI core idle; spi_do valid while high
- mem_we  out  4  block RAM byte write enables
- mem_addr  out  12  block RAM word address
- mem_wdata  out  32  block RAM write data
- cpu_hold  out  1  CPU held in reset while high
- boot_done  out  1  loader finished, pass-through active
- boot_error  out  1  sticky, a byte timed out

## Operation
- Reset values: spi_we 0, spi_di 0, spi_ss_reset 1, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, boot_done 0, boot_error 0, cpu_spi_ready 0, cpu_spi_do 0.
- States: WAKE_TX (send 0xAB) → WAKE_CS (ss_reset pulse) → WAKE_WAIT (WAKE_CYCLES) → CMD (0x03) → A2 → A1 → A0 (FLASH_ADDR MSB first) → DATA (send 0x00, capture spi_do) → FINISH (ss_reset pulse) → DONE. Any timeout → ERROR → FINISH, with boot_error set.
- Byte handshake: spi_we is a one-cycle pulse, issued only when spi_ready=1. The cycle after the pulse, spi_ready is ignored. The byte then completes on the first spi_ready=1. spi_do is sampled in that cycle.
- Timeout: counter cleared at each spi_we. If it reaches TIMEOUT_CYCLES before completion, go to ERROR.
- Word assembly is little-endian: the 1st data byte goes to [7:0] and the 4th to [31:24]. On the 4th byte, mem_we=4'hF for exactly one cycle with mem_addr = word index and mem_wdata = the assembled word. The word index then increments.
- After word LOAD_WORDS-1 is written, go to FINISH. The index never wraps.
- DONE: cpu_hold=0 and boot_done=1. spi_we/spi_di/spi_ss_reset follow cpu_spi_* combinationally; cpu_spi_do=spi_do and cpu_spi_ready=spi_ready. mem_we stays 0.
- Before DONE: cpu_spi_* inputs are ignored, cpu_spi_ready=0 and cpu_spi_do=0.
- ERROR still reaches DONE, so the CPU runs and can read boot_error. boot_error clears only on reset.

## Timing
- spi_ss_reset pulses last exactly 1 cycle in WAKE_CS and FINISH. It is held at 1 only while reset is asserted.
- Per byte: 1 issue cycle + 1 guard cycle + SPI core transfer time. There is no extra gap between consecutive bytes when spi_ready is already high.
- mem_we fires in the cycle after the 4th byte's completion cycle.
- cpu_hold falls in the same cycle boot_done rises, one cycle after the FINISH pulse.
- Reset mid-load: all outputs return to reset values immediately and the sequence restarts from WAKE_TX. Block RAM contents are not cleared.
- A CPU strobe coincident with DONE entry is dropped. Pass-through starts the cycle after boot_done rises.

## Structure
- Package flash_boot_pkg holds the state enum, opcodes OP_RELEASE_PD=8'hAB, OP_READ=8'h03 and OP_DUMMY=8'h00.
- Sub-module flash_byte_xfer implements the issue/guard/wait handshake and the timeout counter. It reports done, timeout and rx_byte.
- Top FSM, word assembler and pass-through mux live in flash_boot_loader.

## Test plan
- Normal boot with LOAD_WORDS=4 and a flash model returning 0x00..0x0F after command 03 10 00 00: MOSI sequence AB, CS release, 03 10 00 00, 16×00. RAM words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C at addr 0..3. Then cpu_hold 0 and boot_done 1.
- Wake spacing: measure from the WAKE_CS pulse to the CMD spi_we. Require ≥ WAKE_CYCLES cycles.
- Timeout with TIMEOUT_CYCLES=100 and the model holding spi_ready low on byte 3: ERROR entered after 100 cycles. One spi_ss_reset pulse, boot_error=1, boot_done=1, no mem_we.
- Reset asserted during word 2 of 4: outputs return to reset values within the same cycle. After release the sequence restarts at 0xAB and all 4 words are written.
- Pass-through: after DONE, CPU writes 0x9F. spi_we/spi_di mirror it in the same cycle, and cpu_spi_do returns the model's byte when cpu_spi_ready=1.
- CPU strobe during load: cpu_spi_we pulses in DATA state are never forwarded to spi_we, and cpu_spi_ready stays 0.
